// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handler for a set-associative cache. Picks a victim way in the
// addressed set, writes it back word by word if dirty, fetches the missing line word
// by word (one read in flight) and writes line+tag into the array via a one-cycle fill strobe.
// Ports: miss request (i_miss_*/o_miss_ready), array lookup (o_lookup_index, o_victim_way,
// i_way_*, i_victim_*), memory request/response (o_mem_*, i_mem_*), fill port (o_fill_*, o_done).
module cache_fill_ctrl #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WAYS            = 4,
  localparam int LINE_SIZE_BITS = LINE_SIZE_BYTES * 8,
  localparam int WORDS          = LINE_SIZE_BITS / DATA_WIDTH,
  localparam int OFFSET_WIDTH   = $clog2(LINE_SIZE_BYTES),
  localparam int INDEX_WIDTH    = $clog2(CACHE_LINES),
  localparam int TAG_BITS       = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WAY_WIDTH      = $clog2(WAYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss_valid,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_address,
  output logic                      o_miss_ready,
  output logic [INDEX_WIDTH-1:0]    o_lookup_index,
  output logic [WAY_WIDTH-1:0]      o_victim_way,
  input  logic [WAYS-1:0]           i_way_valid,
  input  logic [WAYS-1:0]           i_way_dirty,
  input  logic [WAYS-1:0]           i_way_lru,
  input  logic [TAG_BITS-1:0]       i_victim_tag,
  input  logic [LINE_SIZE_BITS-1:0] i_victim_line,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic                      o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_address,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic                      i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_fill_valid,
  output logic [INDEX_WIDTH-1:0]    o_fill_index,
  output logic [WAY_WIDTH-1:0]      o_fill_way,
  output logic [TAG_BITS-1:0]       o_fill_tag,
  output logic [LINE_SIZE_BITS-1:0] o_fill_line,
  output logic                      o_done
);

  localparam int WCW        = $clog2(WORDS);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, WB_REQ, RD_REQ, RD_WAIT, FILL} state_t;

  state_t                    state, state_nxt;
  logic [TAG_BITS-1:0]       miss_tag;
  logic [INDEX_WIDTH-1:0]    index;
  logic [WAY_WIDTH-1:0]      victim_way;
  logic                      victim_dirty;
  logic [TAG_BITS-1:0]       victim_tag;
  logic [LINE_SIZE_BITS-1:0] victim_line;
  logic [LINE_SIZE_BITS-1:0] fill_line;
  logic [WCW-1:0]            word_cnt;
  logic                      last_word;
  logic [OFFSET_WIDTH-1:0]   word_off;
  logic [WAY_WIDTH-1:0]      sel_way;
  logic                      sel_found;

  // Lines are always transferred from word 0, so the byte offset of the miss is irrelevant.
  logic unused_offset;
  assign unused_offset = ^i_miss_address[OFFSET_WIDTH-1:0];

  assign last_word = (word_cnt == WCW'(WORDS - 1));
  assign word_off  = OFFSET_WIDTH'(word_cnt) << BYTE_SHIFT;

  // Victim priority: first invalid way, then first way with lru=0, else way 0.
  always_comb begin
    sel_way   = '0;
    sel_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!sel_found && !i_way_valid[w]) begin
        sel_way   = WAY_WIDTH'(w);
        sel_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!sel_found && !i_way_lru[w]) begin
        sel_way   = WAY_WIDTH'(w);
        sel_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_miss_valid) state_nxt = SELECT;
      SELECT:  state_nxt = LOAD;
      LOAD:    state_nxt = victim_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (i_mem_req_ready && last_word) state_nxt = RD_REQ;
      RD_REQ:  if (i_mem_req_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (i_mem_rvalid) state_nxt = last_word ? FILL : RD_REQ;
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only; nothing from i_mem_* reaches o_mem_*.
  always_comb begin
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_address   = '0;
    o_mem_wdata     = '0;
    o_fill_valid    = 1'b0;
    o_done          = 1'b0;
    case (state)
      IDLE: o_miss_ready = 1'b1;
      WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_we        = 1'b1;
        o_mem_address   = {victim_tag, index, word_off};
        o_mem_wdata     = victim_line[word_cnt*DATA_WIDTH +: DATA_WIDTH];
      end
      RD_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_address   = {miss_tag, index, word_off};
      end
      FILL: begin
        o_fill_valid = 1'b1;
        o_done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_lookup_index = index;
  assign o_victim_way   = victim_way;
  assign o_fill_index   = index;
  assign o_fill_way     = victim_way;
  assign o_fill_tag     = miss_tag;
  assign o_fill_line    = fill_line;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_tag     <= '0;
      index        <= '0;
      victim_way   <= '0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
      victim_line  <= '0;
      fill_line    <= '0;
      word_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (i_miss_valid) begin
          miss_tag <= i_miss_address[ADDRESS_WIDTH-1 -: TAG_BITS];
          index    <= i_miss_address[OFFSET_WIDTH +: INDEX_WIDTH];
        end
        SELECT: begin
          victim_way   <= sel_way;
          victim_dirty <= i_way_valid[sel_way] & i_way_dirty[sel_way];
        end
        LOAD: begin
          victim_tag  <= i_victim_tag;
          victim_line <= i_victim_line;
          word_cnt    <= '0;
        end
        WB_REQ: if (i_mem_req_ready) begin
          word_cnt <= last_word ? '0 : word_cnt + WCW'(1);
        end
        RD_WAIT: if (i_mem_rvalid) begin
          fill_line[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
          word_cnt <= last_word ? '0 : word_cnt + WCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;
  localparam int TAGW  = 18;
  localparam int IDXW  = 8;
  localparam int LBITS = 512;
  localparam int WORDS = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_miss_valid;
  logic [31:0]      i_miss_address;
  logic             o_miss_ready;
  logic [IDXW-1:0]  o_lookup_index;
  logic [1:0]       o_victim_way;
  logic [3:0]       i_way_valid, i_way_dirty, i_way_lru;
  logic [TAGW-1:0]  i_victim_tag;
  logic [LBITS-1:0] i_victim_line;
  logic             o_mem_req_valid;
  logic             i_mem_req_ready;
  logic             o_mem_we;
  logic [31:0]      o_mem_address;
  logic [31:0]      o_mem_wdata;
  logic             i_mem_rvalid;
  logic [31:0]      i_mem_rdata;
  logic             o_fill_valid;
  logic [IDXW-1:0]  o_fill_index;
  logic [1:0]       o_fill_way;
  logic [TAGW-1:0]  o_fill_tag;
  logic [LBITS-1:0] o_fill_line;
  logic             o_done;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .i_miss_valid(i_miss_valid), .i_miss_address(i_miss_address), .o_miss_ready(o_miss_ready),
    .o_lookup_index(o_lookup_index), .o_victim_way(o_victim_way),
    .i_way_valid(i_way_valid), .i_way_dirty(i_way_dirty), .i_way_lru(i_way_lru),
    .i_victim_tag(i_victim_tag), .i_victim_line(i_victim_line),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_we(o_mem_we),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_fill_valid(o_fill_valid), .o_fill_index(o_fill_index), .o_fill_way(o_fill_way),
    .o_fill_tag(o_fill_tag), .o_fill_line(o_fill_line), .o_done(o_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Cache array model: status of the serviced set plus per-way tag/line contents.
  logic [3:0]       way_valid, way_dirty, way_lru;
  logic [TAGW-1:0]  way_tag  [4];
  logic [LBITS-1:0] way_line [4];
  assign i_way_valid   = way_valid;
  assign i_way_dirty   = way_dirty;
  assign i_way_lru     = way_lru;
  assign i_victim_tag  = way_tag[o_victim_way];
  assign i_victim_line = way_line[o_victim_way];

  // Backing memory contents: a fixed scramble of the word address.
  logic [31:0] mem_seed;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Observations from one serviced miss
  logic [LBITS-1:0] obs_wa, obs_wd, obs_ra, obs_line;
  logic [TAGW-1:0]  obs_tag;
  logic [IDXW-1:0]  obs_idx;
  logic [1:0]       obs_way;
  int n_wr, n_rd, fill_cnt, fill_cyc, accept_cnt, proto_err, post_req, post_fill;
  logic ready_after;
  bit   timed_out;

  // Reference expectations
  logic [LBITS-1:0] exp_wa, exp_wd, exp_ra, exp_line;
  logic [TAGW-1:0]  exp_tag;
  logic [IDXW-1:0]  exp_idx;
  int               exp_way, exp_wr_cnt;

  function automatic int ref_victim(input logic [3:0] v, input logic [3:0] l);
    for (int w = 0; w < 4; w++) if (!v[w]) return w;
    for (int w = 0; w < 4; w++) if (!l[w]) return w;
    return 0;
  endfunction

  task automatic build_expect(input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] wbase;
    int v;
    v       = ref_victim(way_valid, way_lru);
    exp_way = v;
    exp_idx = IDXW'((a / 64) % 256);
    exp_tag = TAGW'(a / 16384);
    base    = a - (a % 64);
    wbase   = 32'(way_tag[v]) * 16384 + 32'(exp_idx) * 64;
    exp_wa = '0; exp_wd = '0; exp_ra = '0; exp_line = '0;
    exp_wr_cnt = (way_valid[v] && way_dirty[v]) ? WORDS : 0;
    for (int k = 0; k < WORDS; k++) begin
      if (exp_wr_cnt != 0) begin
        exp_wa[k*32 +: 32] = wbase + 32'(4 * k);
        exp_wd[k*32 +: 32] = way_line[v][k*32 +: 32];
      end
      exp_ra[k*32 +: 32]   = base + 32'(4 * k);
      exp_line[k*32 +: 32] = mem_word(base + 32'(4 * k));
    end
  endtask

  task automatic randomize_ways();
    for (int w = 0; w < 4; w++) begin
      way_tag[w] = TAGW'($urandom);
      for (int k = 0; k < WORDS; k++) way_line[w][k*32 +: 32] = $urandom;
    end
    mem_seed = $urandom;
  endtask

  // Drives one miss and acts as the memory; rdy_mode 0=always ready, 1=toggle, 2=random.
  // rv_delay 0 = random 1..4 cycles. abort_after>0 pulses reset after that many write beats.
  task automatic run_miss(input logic [31:0] addr, input int rdy_mode, input int rv_delay,
                          input bit hold_valid, input bit spurious, input int abort_after);
    int cyc, rv_due, outstanding, budget;
    bit started, done, rdy, prev_stall, prev_we;
    logic [31:0] rv_data, prev_addr, prev_wdata;
    cyc = 0; rv_due = -1; outstanding = 0; started = 0; done = 0; prev_stall = 0;
    prev_we = 0; prev_addr = '0; prev_wdata = '0; rv_data = '0; rdy = 0;
    n_wr = 0; n_rd = 0; obs_wa = '0; obs_wd = '0; obs_ra = '0; obs_line = '0;
    obs_tag = '0; obs_idx = '0; obs_way = '0;
    fill_cnt = 0; fill_cyc = -1; accept_cnt = 0; proto_err = 0;
    post_req = 0; post_fill = 0; ready_after = 1'b0; timed_out = 0;
    if (spurious) begin
      @(negedge clk); i_mem_rvalid = 1'b1; i_mem_rdata = $urandom;
      @(negedge clk); i_mem_rvalid = 1'b0;
    end
    @(negedge clk);
    i_miss_valid = 1'b1; i_miss_address = addr;
    for (budget = 0; budget < 3000 && !done; budget++) begin
      if (started) cyc++;
      if (fill_cnt > 0 && cyc == fill_cyc + 1) begin
        ready_after = o_miss_ready;
        i_miss_valid = 1'b0; i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0;
        done = 1;
      end else if (abort_after > 0 && n_wr == abort_after) begin
        i_miss_valid = 1'b0; i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ready_after = o_miss_ready;
        for (int j = 0; j < 40; j++) begin
          i_mem_req_ready = 1'b1;
          if (o_mem_req_valid) post_req++;
          if (o_fill_valid) post_fill++;
          @(negedge clk);
        end
        i_mem_req_ready = 1'b0;
        done = 1;
      end else begin
        if (!hold_valid && started) i_miss_valid = 1'b0;
        if (i_miss_valid && o_miss_ready) begin
          accept_cnt++;
          if (!started) begin started = 1; cyc = 0; end
        end
        if (o_done !== o_fill_valid) proto_err++;
        if (o_fill_valid) begin
          fill_cnt++; fill_cyc = cyc;
          obs_line = o_fill_line; obs_tag = o_fill_tag; obs_idx = o_fill_index; obs_way = o_fill_way;
        end
        i_mem_rvalid = 1'b0;
        if (started && rv_due == cyc) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = rv_data; outstanding--; rv_due = -1;
        end else if (spurious && o_mem_req_valid && o_mem_we) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = $urandom;
        end
        case (rdy_mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 1);
          default: rdy = ($urandom_range(0, 1) == 1);
        endcase
        i_mem_req_ready = rdy;
        if (prev_stall && (o_mem_req_valid !== 1'b1 || o_mem_address !== prev_addr ||
                           o_mem_we !== prev_we || (prev_we && o_mem_wdata !== prev_wdata)))
          proto_err++;
        prev_stall = 0;
        if (o_mem_req_valid) begin
          if (rdy) begin
            if (o_mem_we) begin
              if (n_wr < WORDS) begin
                obs_wa[n_wr*32 +: 32] = o_mem_address;
                obs_wd[n_wr*32 +: 32] = o_mem_wdata;
              end
              n_wr++;
            end else begin
              if (outstanding != 0) proto_err++;
              if (n_rd < WORDS) obs_ra[n_rd*32 +: 32] = o_mem_address;
              n_rd++;
              outstanding++;
              rv_due  = cyc + ((rv_delay > 0) ? rv_delay : int'($urandom_range(1, 4)));
              rv_data = mem_word(o_mem_address);
            end
          end else begin
            prev_stall = 1; prev_addr = o_mem_address; prev_we = o_mem_we; prev_wdata = o_mem_wdata;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) timed_out = 1;
    i_miss_valid = 1'b0; i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_miss_valid = 1'b0; i_miss_address = '0;
    i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    way_valid = '0; way_dirty = '0; way_lru = '0;
    randomize_ways();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (o_miss_ready !== 1'b1) begin n_bad++; $display("FAIL reset_miss_ready got %b want 1", o_miss_ready); end
    n_cmp++; if (o_mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req_valid got %b want 0", o_mem_req_valid); end
    n_cmp++; if (o_fill_valid !== 1'b0 || o_done !== 1'b0) begin n_bad++; $display("FAIL reset_fill got %b/%b want 0/0", o_fill_valid, o_done); end
    n_cmp++; if (o_mem_address !== 32'h0 || o_mem_wdata !== 32'h0 || o_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_bus got %h/%h/%b want 0", o_mem_address, o_mem_wdata, o_mem_we); end
    n_cmp++; if (o_lookup_index !== 8'h0 || o_victim_way !== 2'd0 || o_fill_tag !== 18'h0) begin n_bad++; $display("FAIL reset_regs got %h/%0d/%h want 0", o_lookup_index, o_victim_way, o_fill_tag); end
    n_cmp++; if (o_fill_line !== {LBITS{1'b0}}) begin n_bad++; $display("FAIL reset_fill_line got %h want 0", o_fill_line); end
  endtask

  task automatic test_clean_miss();
    logic [31:0] a;
    a = 32'h0000_1240;
    randomize_ways();
    way_valid = 4'b0000; way_dirty = 4'b1111; way_lru = 4'b0000;
    build_expect(a);
    run_miss(a, 0, 1, 0, 0, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL clean_timeout got no fill want fill"); end
    n_cmp++; if (obs_way !== 2'd0) begin n_bad++; $display("FAIL clean_way got %0d want 0", obs_way); end
    n_cmp++; if (obs_idx !== 8'h49) begin n_bad++; $display("FAIL clean_index got %h want 49", obs_idx); end
    n_cmp++; if (obs_tag !== exp_tag) begin n_bad++; $display("FAIL clean_tag got %h want %h", obs_tag, exp_tag); end
    n_cmp++; if (fill_cyc !== 35) begin n_bad++; $display("FAIL clean_fill_cycle got %0d want 35", fill_cyc); end
    n_cmp++; if (ready_after !== 1'b1) begin n_bad++; $display("FAIL clean_ready_after got %b want 1", ready_after); end
    n_cmp++; if (n_wr !== 0 || n_rd !== WORDS) begin n_bad++; $display("FAIL clean_beats got wr=%0d rd=%0d want wr=0 rd=16", n_wr, n_rd); end
    n_cmp++; if (obs_ra[31:0] !== 32'h1240 || obs_ra[511:480] !== 32'h127C) begin n_bad++; $display("FAIL clean_rd_ends got %h..%h want 1240..127c", obs_ra[31:0], obs_ra[511:480]); end
    n_cmp++; if (obs_ra !== exp_ra) begin n_bad++; $display("FAIL clean_rd_addr got %h want %h", obs_ra, exp_ra); end
    n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL clean_line got %h want %h", obs_line, exp_line); end
    n_cmp++; if (fill_cnt !== 1 || proto_err !== 0) begin n_bad++; $display("FAIL clean_protocol got fills=%0d errs=%0d want 1/0", fill_cnt, proto_err); end
  endtask

  task automatic test_dirty_writeback();
    logic [31:0] a;
    a = 32'h0000_1240;
    randomize_ways();
    way_valid = 4'b1111; way_dirty = 4'b0100; way_lru = 4'b1011; way_tag[2] = 18'h3FFFF;
    build_expect(a);
    run_miss(a, 0, 1, 0, 0, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL dirty_timeout got no fill want fill"); end
    n_cmp++; if (obs_way !== 2'd2) begin n_bad++; $display("FAIL dirty_way got %0d want 2", obs_way); end
    n_cmp++; if (n_wr !== 16 || n_rd !== 16) begin n_bad++; $display("FAIL dirty_beats got wr=%0d rd=%0d want 16/16", n_wr, n_rd); end
    n_cmp++; if (obs_wa !== exp_wa) begin n_bad++; $display("FAIL dirty_wr_addr got %h want %h", obs_wa, exp_wa); end
    n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL dirty_wr_data got %h want %h", obs_wd, exp_wd); end
    n_cmp++; if (fill_cyc !== 51) begin n_bad++; $display("FAIL dirty_fill_cycle got %0d want 51", fill_cyc); end
    n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL dirty_line got %h want %h", obs_line, exp_line); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = 32'h0000_1240;
    randomize_ways();
    way_valid = 4'b1111; way_dirty = 4'b0100; way_lru = 4'b1011;
    build_expect(a);
    run_miss(a, 1, 3, 0, 0, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout got no fill want fill"); end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL bp_protocol got %0d errors want 0", proto_err); end
    n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL bp_wr_data got %h want %h", obs_wd, exp_wd); end
    n_cmp++; if (obs_ra !== exp_ra) begin n_bad++; $display("FAIL bp_rd_addr got %h want %h", obs_ra, exp_ra); end
    n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL bp_line got %h want %h", obs_line, exp_line); end
  endtask

  task automatic test_spurious();
    logic [31:0] a;
    a = 32'h0123_4580;
    randomize_ways();
    way_valid = 4'b1111; way_dirty = 4'b1111; way_lru = 4'b1110;
    build_expect(a);
    run_miss(a, 0, 1, 1, 1, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL spur_timeout got no fill want fill"); end
    n_cmp++; if (accept_cnt !== 1 || fill_cnt !== 1) begin n_bad++; $display("FAIL spur_accepts got acc=%0d fills=%0d want 1/1", accept_cnt, fill_cnt); end
    n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL spur_wr_data got %h want %h", obs_wd, exp_wd); end
    n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL spur_line got %h want %h", obs_line, exp_line); end
  endtask

  task automatic test_reset_mid_writeback();
    logic [31:0] a;
    a = 32'h0000_1240;
    randomize_ways();
    way_valid = 4'b1111; way_dirty = 4'b0100; way_lru = 4'b1011;
    run_miss(a, 0, 1, 0, 0, 5);
    n_cmp++; if (n_wr !== 5 || n_rd !== 0) begin n_bad++; $display("FAIL abort_beats got wr=%0d rd=%0d want 5/0", n_wr, n_rd); end
    n_cmp++; if (ready_after !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", ready_after); end
    n_cmp++; if (post_req !== 0 || post_fill !== 0 || fill_cnt !== 0) begin n_bad++; $display("FAIL abort_quiet got req=%0d fill=%0d/%0d want 0", post_req, post_fill, fill_cnt); end
    a = 32'h0000_1240;
    way_valid = 4'b1111; way_dirty = 4'b0000; way_lru = 4'b0111;
    build_expect(a);
    run_miss(a, 0, 1, 0, 0, 0);
    n_cmp++; if (fill_cyc !== 35 || obs_way !== 2'd3) begin n_bad++; $display("FAIL abort_followup got cyc=%0d way=%0d want 35/3", fill_cyc, obs_way); end
    n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL abort_followup_line got %h want %h", obs_line, exp_line); end
  endtask

  task automatic test_victim_select();
    logic [3:0] lrus [2];
    int         want [2];
    lrus[0] = 4'b1111; want[0] = 0;
    lrus[1] = 4'b1101; want[1] = 1;
    for (int i = 0; i < 2; i++) begin
      randomize_ways();
      way_valid = 4'b1111; way_dirty = 4'b0000; way_lru = lrus[i];
      run_miss(32'h8000_0000 + 32'(i * 64), 0, 1, 0, 0, 0);
      n_cmp++; if (obs_way !== 2'(want[i]) || timed_out) begin n_bad++; $display("FAIL victim_lru%0d got %0d want %0d", i, obs_way, want[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      randomize_ways();
      a = $urandom;
      way_valid = 4'($urandom); way_dirty = 4'($urandom); way_lru = 4'($urandom);
      build_expect(a);
      run_miss(a, 2, 0, i[0], i[1], 0);
      n_cmp++; if (timed_out || fill_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_fill got fills=%0d want 1", i, fill_cnt); end
      n_cmp++; if (obs_way !== 2'(exp_way)) begin n_bad++; $display("FAIL rnd%0d_way got %0d want %0d", i, obs_way, exp_way); end
      n_cmp++; if (obs_tag !== exp_tag || obs_idx !== exp_idx) begin n_bad++; $display("FAIL rnd%0d_tagidx got %h/%h want %h/%h", i, obs_tag, obs_idx, exp_tag, exp_idx); end
      n_cmp++; if (n_wr !== exp_wr_cnt || n_rd !== WORDS) begin n_bad++; $display("FAIL rnd%0d_beats got wr=%0d rd=%0d want %0d/16", i, n_wr, n_rd, exp_wr_cnt); end
      n_cmp++; if (obs_wa !== exp_wa || obs_wd !== exp_wd) begin n_bad++; $display("FAIL rnd%0d_wb got %h want %h", i, obs_wa, exp_wa); end
      n_cmp++; if (obs_ra !== exp_ra) begin n_bad++; $display("FAIL rnd%0d_rd_addr got %h want %h", i, obs_ra, exp_ra); end
      n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL rnd%0d_line got %h want %h", i, obs_line, exp_line); end
      n_cmp++; if (proto_err !== 0 || accept_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_protocol got errs=%0d acc=%0d want 0/1", i, proto_err, accept_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_writeback();
    test_backpressure();
    test_spurious();
    test_reset_mid_writeback();
    test_victim_select();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
